// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Purpose:
//   Clocked state generator for the CPU control path. Produces the 8-bit state
//   code consumed by the combinational control-signal decoder. Each instruction
//   runs the fetch prologue (0x00 -> 0x0F -> 0x01), then branches on the opcode
//   in instr[15:12] into a fixed execute micro-sequence, then returns to 0x00.
//
// Ports:
//   clk         in   1   system clock, rising-edge active
//   resetn      in   1   asynchronous active-low reset
//   run         in   1   advance enable; low holds every register
//   instr       in   16  instruction register; only [15:12] is used
//   state       out  8   current state code to the control-signal decoder
//   fetch       out  1   high in 0x00, 0x0F, 0x01
//   instr_done  out  1   high in the final execute state of each chain
//   illegal     out  1   sticky; set on an unassigned opcode or unreachable code
//   halted      out  1   high in the halt state (0xFF), otherwise 0
//
// Build option:
//   CONTROL_SEQUENCER_HALT_EN  when defined, opcode F enters 0xFF and stays
//                              there until reset. When undefined, opcode F is
//                              illegal and halted is tied low.
//
// State table (state | meaning):
//   0x00 | fetch 0: present PC to RAM
//   0x0F | fetch 1: latch RAM output into instruction register
//   0x01 | decode: sample opcode, dispatch
//   0x02 | load   (final)
//   0x03 | move   (final)
//   0x04 | ldpc   (final)
//   0x05 | branch (final)
//   0x06 | sub 1      0x07 | sub 2      0x08 | sub 3 (final)
//   0x09 | add 1      0x0A | add 2      0x0B | add 3 (final)
//   0x0C | xor 1      0x0D | xor 2      0x0E | xor 3 (final)
//   0x13 | push 1     0x14 | push 2     0x15 | push 3     0x16 | push 4 (final)
//   0x17 | pop 1      0x18 | pop 2      0x19 | pop 3      0x1A | pop 4 (final)
//   0x1B..0x20 | call 1..6              0x25 | call 7 (final)
//   0x21 | ret 1      0x22 | ret 2      0x23 | ret 3      0x24 | ret 4 (final)
//   0xFF | halt (only with CONTROL_SEQUENCER_HALT_EN)
//   other| unreachable: go to 0x00 and flag illegal
// -----------------------------------------------------------------------------

module control_sequencer #(
    parameter int STATE_W = 8,
    parameter int OPC_W   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    input  logic [15:0]        instr,
    output logic [STATE_W-1:0] state,
    output logic               fetch,
    output logic               instr_done,
    output logic               illegal,
    output logic               halted
);

    // Fetch / decode
    localparam logic [STATE_W-1:0] S_FETCH0  = 8'h00;
    localparam logic [STATE_W-1:0] S_FETCH1  = 8'h0F;
    localparam logic [STATE_W-1:0] S_DECODE  = 8'h01;
    // Single-cycle execute
    localparam logic [STATE_W-1:0] S_LOAD    = 8'h02;
    localparam logic [STATE_W-1:0] S_MOVE    = 8'h03;
    localparam logic [STATE_W-1:0] S_LDPC    = 8'h04;
    localparam logic [STATE_W-1:0] S_BRANCH  = 8'h05;
    // ALU chains
    localparam logic [STATE_W-1:0] S_SUB1    = 8'h06;
    localparam logic [STATE_W-1:0] S_SUB2    = 8'h07;
    localparam logic [STATE_W-1:0] S_SUB3    = 8'h08;
    localparam logic [STATE_W-1:0] S_ADD1    = 8'h09;
    localparam logic [STATE_W-1:0] S_ADD2    = 8'h0A;
    localparam logic [STATE_W-1:0] S_ADD3    = 8'h0B;
    localparam logic [STATE_W-1:0] S_XOR1    = 8'h0C;
    localparam logic [STATE_W-1:0] S_XOR2    = 8'h0D;
    localparam logic [STATE_W-1:0] S_XOR3    = 8'h0E;
    // Stack chains
    localparam logic [STATE_W-1:0] S_PUSH1   = 8'h13;
    localparam logic [STATE_W-1:0] S_PUSH2   = 8'h14;
    localparam logic [STATE_W-1:0] S_PUSH3   = 8'h15;
    localparam logic [STATE_W-1:0] S_PUSH4   = 8'h16;
    localparam logic [STATE_W-1:0] S_POP1    = 8'h17;
    localparam logic [STATE_W-1:0] S_POP2    = 8'h18;
    localparam logic [STATE_W-1:0] S_POP3    = 8'h19;
    localparam logic [STATE_W-1:0] S_POP4    = 8'h1A;
    // Call / return
    localparam logic [STATE_W-1:0] S_CALL1   = 8'h1B;
    localparam logic [STATE_W-1:0] S_CALL2   = 8'h1C;
    localparam logic [STATE_W-1:0] S_CALL3   = 8'h1D;
    localparam logic [STATE_W-1:0] S_CALL4   = 8'h1E;
    localparam logic [STATE_W-1:0] S_CALL5   = 8'h1F;
    localparam logic [STATE_W-1:0] S_CALL6   = 8'h20;
    localparam logic [STATE_W-1:0] S_CALL7   = 8'h25;
    localparam logic [STATE_W-1:0] S_RET1    = 8'h21;
    localparam logic [STATE_W-1:0] S_RET2    = 8'h22;
    localparam logic [STATE_W-1:0] S_RET3    = 8'h23;
    localparam logic [STATE_W-1:0] S_RET4    = 8'h24;
    // Halt
    localparam logic [STATE_W-1:0] S_HALT    = 8'hFF;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 4'h0;
    localparam logic [OPC_W-1:0] OPC_MOVE   = 4'h1;
    localparam logic [OPC_W-1:0] OPC_LDPC   = 4'h2;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 4'h3;
    localparam logic [OPC_W-1:0] OPC_SUB    = 4'h4;
    localparam logic [OPC_W-1:0] OPC_ADD    = 4'h5;
    localparam logic [OPC_W-1:0] OPC_XOR    = 4'h6;
    localparam logic [OPC_W-1:0] OPC_PUSH   = 4'h7;
    localparam logic [OPC_W-1:0] OPC_POP    = 4'h8;
    localparam logic [OPC_W-1:0] OPC_CALL   = 4'h9;
    localparam logic [OPC_W-1:0] OPC_RET    = 4'hA;
`ifdef CONTROL_SEQUENCER_HALT_EN
    localparam logic [OPC_W-1:0] OPC_HALT   = 4'hF;
`endif

    logic [OPC_W-1:0]   opcode;
    logic [STATE_W-1:0] state_nxt;
    logic               set_illegal;
    logic               unused_instr;

    assign opcode = instr[15 -: OPC_W];

    // Operand bits belong to the datapath, not to sequencing.
    assign unused_instr = &{1'b0, instr[15-OPC_W:0]};

    // -------------------------------------------------------------------------
    // Opcode decode: only consulted while in S_DECODE, so instr changes in any
    // other state cannot disturb a running chain.
    // -------------------------------------------------------------------------
    logic [STATE_W-1:0] dispatch;
    logic               dispatch_bad;

    always_comb begin
        dispatch     = S_FETCH0;
        dispatch_bad = 1'b0;
        case (opcode)
            OPC_LOAD:   dispatch = S_LOAD;
            OPC_MOVE:   dispatch = S_MOVE;
            OPC_LDPC:   dispatch = S_LDPC;
            OPC_BRANCH: dispatch = S_BRANCH;
            OPC_SUB:    dispatch = S_SUB1;
            OPC_ADD:    dispatch = S_ADD1;
            OPC_XOR:    dispatch = S_XOR1;
            OPC_PUSH:   dispatch = S_PUSH1;
            OPC_POP:    dispatch = S_POP1;
            OPC_CALL:   dispatch = S_CALL1;
            OPC_RET:    dispatch = S_RET1;
`ifdef CONTROL_SEQUENCER_HALT_EN
            OPC_HALT:   dispatch = S_HALT;
`endif
            // Unassigned opcodes behave as a NOP: straight back to fetch
            // without touching the PC.
            default: begin
                dispatch     = S_FETCH0;
                dispatch_bad = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Successor function
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = S_FETCH0;
        set_illegal = 1'b0;
        case (state)
            S_FETCH0: state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt   = dispatch;
                set_illegal = dispatch_bad;
            end

            S_LOAD, S_MOVE, S_LDPC, S_BRANCH: state_nxt = S_FETCH0;

            S_SUB1:  state_nxt = S_SUB2;
            S_SUB2:  state_nxt = S_SUB3;
            S_SUB3:  state_nxt = S_FETCH0;

            S_ADD1:  state_nxt = S_ADD2;
            S_ADD2:  state_nxt = S_ADD3;
            S_ADD3:  state_nxt = S_FETCH0;

            S_XOR1:  state_nxt = S_XOR2;
            S_XOR2:  state_nxt = S_XOR3;
            S_XOR3:  state_nxt = S_FETCH0;

            S_PUSH1: state_nxt = S_PUSH2;
            S_PUSH2: state_nxt = S_PUSH3;
            S_PUSH3: state_nxt = S_PUSH4;
            S_PUSH4: state_nxt = S_FETCH0;

            S_POP1:  state_nxt = S_POP2;
            S_POP2:  state_nxt = S_POP3;
            S_POP3:  state_nxt = S_POP4;
            S_POP4:  state_nxt = S_FETCH0;

            S_CALL1: state_nxt = S_CALL2;
            S_CALL2: state_nxt = S_CALL3;
            S_CALL3: state_nxt = S_CALL4;
            S_CALL4: state_nxt = S_CALL5;
            S_CALL5: state_nxt = S_CALL6;
            S_CALL6: state_nxt = S_CALL7;
            S_CALL7: state_nxt = S_FETCH0;

            S_RET1:  state_nxt = S_RET2;
            S_RET2:  state_nxt = S_RET3;
            S_RET3:  state_nxt = S_RET4;
            S_RET4:  state_nxt = S_FETCH0;

`ifdef CONTROL_SEQUENCER_HALT_EN
            S_HALT:  state_nxt = S_HALT;
`endif

            // Codes the sequencer never produces; recover to fetch and flag it.
            default: begin
                state_nxt   = S_FETCH0;
                set_illegal = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and sticky flag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_FETCH0;
            illegal <= 1'b0;
        end else if (run) begin
            state <= state_nxt;
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decodes of state
    // -------------------------------------------------------------------------
    always_comb begin
        fetch = (state == S_FETCH0) || (state == S_FETCH1) || (state == S_DECODE);
    end

    always_comb begin
        case (state)
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH,
            S_SUB3, S_ADD3, S_XOR3,
            S_PUSH4, S_POP4, S_CALL7, S_RET4: instr_done = 1'b1;
            default:                          instr_done = 1'b0;
        endcase
    end

`ifdef CONTROL_SEQUENCER_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] instr;
    logic [7:0]  state;
    logic        fetch;
    logic        instr_done;
    logic        illegal;
    logic        halted;

    int n_cmp;
    int n_fail;

`ifdef CONTROL_SEQUENCER_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    control_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .instr      (instr),
        .state      (state),
        .fetch      (fetch),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the CPU as a list of upcoming state codes.
    // ------------------------------------------------------------------
    typedef logic [7:0] q8_t[$];

    logic [7:0] m_state;
    logic       m_illegal;
    q8_t        m_seq;

    function automatic q8_t exec_list(input int opc);
        q8_t q;
        case (opc)
            0:  q = '{8'h02};
            1:  q = '{8'h03};
            2:  q = '{8'h04};
            3:  q = '{8'h05};
            4:  q = '{8'h06, 8'h07, 8'h08};
            5:  q = '{8'h09, 8'h0A, 8'h0B};
            6:  q = '{8'h0C, 8'h0D, 8'h0E};
            7:  q = '{8'h13, 8'h14, 8'h15, 8'h16};
            8:  q = '{8'h17, 8'h18, 8'h19, 8'h1A};
            9:  q = '{8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h25};
            10: q = '{8'h21, 8'h22, 8'h23, 8'h24};
            default: q = {};
        endcase
        return q;
    endfunction

    function automatic bit is_final(input logic [7:0] s);
        q8_t q;
        for (int o = 0; o < 11; o++) begin
            q = exec_list(o);
            if (q[q.size()-1] == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state   = 8'h00;
        m_illegal = 1'b0;
        m_seq     = '{8'h0F, 8'h01};
    endtask

    task automatic model_step();
        int opc;
        if (!run) return;
        if (HALT_EN && m_state == 8'hFF) return;
        if (m_state == 8'h01) begin
            opc = int'(instr[15:12]);
            if (opc <= 10) begin
                m_seq = exec_list(opc);
                m_seq.push_back(8'h00);
                m_seq.push_back(8'h0F);
                m_seq.push_back(8'h01);
            end else if (HALT_EN && opc == 15) begin
                m_seq = '{8'hFF};
            end else begin
                m_illegal = 1'b1;
                m_seq = '{8'h00, 8'h0F, 8'h01};
            end
        end
        m_state = m_seq.pop_front();
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        check({tag, " state"},      32'(state),      32'(m_state));
        check({tag, " fetch"},      32'(fetch),      32'(m_state == 8'h00 || m_state == 8'h0F || m_state == 8'h01));
        check({tag, " instr_done"}, 32'(instr_done), 32'(is_final(m_state)));
        check({tag, " illegal"},    32'(illegal),    32'(m_illegal));
        check({tag, " halted"},     32'(halted),     32'(HALT_EN && m_state == 8'hFF));
    endtask

    // Advance one edge; leaves time at posedge + 1.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset pulse, asserted between edges, released on a negedge.
    task automatic pulse_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] opc;
        int         latency;
        logic [7:0] disp;
        logic       ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] exp_seq[6];
        logic       exp_done[6];
        int         cycles;
        int         dones;
        logic [7:0] disp_seen;

        n_cmp  = 0;
        n_fail = 0;
        run    = 1'b0;
        instr  = 16'h0000;
        resetn = 1'b0;
        model_reset();

        vecs[0]  = '{4'h0, 4,  8'h02, 1'b0};
        vecs[1]  = '{4'h1, 4,  8'h03, 1'b0};
        vecs[2]  = '{4'h2, 4,  8'h04, 1'b0};
        vecs[3]  = '{4'h3, 4,  8'h05, 1'b0};
        vecs[4]  = '{4'h4, 6,  8'h06, 1'b0};
        vecs[5]  = '{4'h5, 6,  8'h09, 1'b0};
        vecs[6]  = '{4'h6, 6,  8'h0C, 1'b0};
        vecs[7]  = '{4'h7, 7,  8'h13, 1'b0};
        vecs[8]  = '{4'h8, 7,  8'h17, 1'b0};
        vecs[9]  = '{4'h9, 10, 8'h1B, 1'b0};
        vecs[10] = '{4'hA, 7,  8'h21, 1'b0};
        vecs[11] = '{4'hB, 3,  8'h00, 1'b1};
        vecs[12] = '{4'hE, 3,  8'h00, 1'b1};

        #17;
        check("reset state",   32'(state),      32'h00);
        check("reset fetch",   32'(fetch),      32'h1);
        check("reset done",    32'(instr_done), 32'h0);
        check("reset illegal", 32'(illegal),    32'h0);
        check("reset halted",  32'(halted),     32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- reset mid-add, then fetch ----------------
        run   = 1'b1;
        instr = 16'h5120;
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset add2", 32'(state), 32'h0A);
        resetn = 1'b0;
        model_reset();
        #1;
        check("async reset state",   32'(state),   32'h00);
        check("async reset illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("fetch step1", 32'(state), 32'h0F);
        tick();
        check("fetch step2", 32'(state), 32'h01);

        // ---------------- add sequence ----------------
        pulse_reset();
        instr = 16'h5120;
        exp_seq  = '{8'h0F, 8'h01, 8'h09, 8'h0A, 8'h0B, 8'h00};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("add seq state", 32'(state),      32'(exp_seq[i]));
            check("add seq done",  32'(instr_done), 32'(exp_done[i]));
        end

        // ---------------- call with stall in 0x1D ----------------
        pulse_reset();
        instr = 16'h9000;
        for (int i = 0; i < 5; i++) tick();
        check("call reach 1D", 32'(state), 32'h1D);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("call stall state", 32'(state), 32'h1D);
        end
        run = 1'b1;
        exp_seq  = '{8'h1E, 8'h1F, 8'h20, 8'h25, 8'h00, 8'h0F};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("call tail state", 32'(state),      32'(exp_seq[i]));
            check("call tail done",  32'(instr_done), 32'(exp_done[i]));
        end

        // ---------------- stall in a final state keeps done high ----------------
        pulse_reset();
        instr = 16'h0000;
        for (int i = 0; i < 3; i++) tick();
        run = 1'b0;
        tick();
        check("stall final state", 32'(state),      32'h02);
        check("stall final done",  32'(instr_done), 32'h1);
        run = 1'b1;

        // ---------------- illegal opcode then legal move ----------------
        pulse_reset();
        instr = 16'hC000;
        tick();
        tick();
        check("illegal at decode", 32'(state), 32'h01);
        tick();
        check("illegal next state", 32'(state),   32'h00);
        check("illegal set",        32'(illegal), 32'h1);
        instr = 16'h1340;
        tick();
        tick();
        tick();
        check("move after illegal state", 32'(state),   32'h03);
        check("illegal sticky",           32'(illegal), 32'h1);
        tick();
        check("move returns", 32'(state), 32'h00);

        // ---------------- opcode stability during push ----------------
        pulse_reset();
        instr = 16'h7000;
        for (int i = 0; i < 4; i++) tick();
        check("push reach 14", 32'(state), 32'h14);
        instr = 16'h0000;
        exp_seq = '{8'h15, 8'h16, 8'h00, 8'h0F, 8'h01, 8'h02};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("push tail state", 32'(state), 32'(exp_seq[i]));
        end

        // ---------------- halt / opcode F ----------------
        pulse_reset();
        instr = 16'hF000;
        tick();
        tick();
        tick();
        if (HALT_EN) begin
            for (int i = 0; i < 22; i++) begin
                check("halt state",   32'(state),   32'hFF);
                check("halt flag",    32'(halted),  32'h1);
                check("halt illegal", 32'(illegal), 32'h0);
                run = (i % 5 != 3);
                tick();
            end
            run = 1'b1;
        end else begin
            check("opcode F state",   32'(state),   32'h00);
            check("opcode F illegal", 32'(illegal), 32'h1);
            check("opcode F halted",  32'(halted),  32'h0);
        end
        resetn = 1'b0;
        model_reset();
        #1;
        check("halt exit state",  32'(state),  32'h00);
        check("halt exit halted", 32'(halted), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- table: every opcode, latency and dispatch ----------------
        pulse_reset();
        run = 1'b1;
        for (int v = 0; v < 13; v++) begin
            instr     = {vecs[v].opc, 12'($urandom)};
            cycles    = 0;
            dones     = 0;
            disp_seen = 8'h00;
            do begin
                tick();
                cycles++;
                if (cycles == 3) disp_seen = state;
                if (instr_done) dones++;
            end while (state != 8'h00 && cycles < 30);
            check("table latency",  32'(cycles),    32'(vecs[v].latency));
            check("table dispatch", 32'(disp_seen), 32'(vecs[v].disp));
            check("table done cnt", 32'(dones),     32'(vecs[v].ill ? 0 : 1));
            check("table illegal",  32'(illegal),   32'(vecs[v].ill));
        end

        // ---------------- randomized run against the model ----------------
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            run   = ($urandom_range(0, 3) != 0);
            instr = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                resetn = 1'b0;
                model_reset();
                #1;
                cmp_model("rand reset");
                @(negedge clk);
                resetn = 1'b1;
            end
            tick();
            cmp_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Clocked state generator that drives the 8-bit `state` code consumed by the combinational control-signal decoder. That decoder turns each code into register, ALU, PC, RAM and SP strobes.
- Steps through fetch (0x00 → 0x0F → 0x01), then branches to the execute micro-sequence selected by opcode `instr[15:12]`, then returns to fetch.
- Sits between the instruction register and the control-signal decoder. Owns all instruction-level timing of the CPU.

Parameters:
- `STATE_W`, 8, width of the state code (fixed by the decoder interface).
- `OPC_W`, 4, width of the opcode field `instr[15:12]`.

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `run`  input  1  advance enable; when low, `state` holds (single-step / stall).
- `instr`  input  16  instruction register contents; only bits [15:12] are used.
- `state`  output  8  current state code to the control-signal decoder.
- `fetch`  output  1  high while `state` is 0x00, 0x0F or 0x01.
- `instr_done`  output  1  one-cycle pulse on the final execute state of each instruction.
- `illegal`  output  1  sticky flag; set when an unassigned opcode is decoded.
- `halted`  output  1  high while in halt state (feature-dependent, else tied 0).

Behaviour:
- **Reset.** Asynchronous assert while `resetn`=0: `state`=0x00, `illegal`=0, `halted`=0. `fetch`=1 and `instr_done`=0 follow from `state`=0x00. Reset mid-sequence abandons the instruction immediately; there is no completion of pending RAM writes.
- **Advance rule.** On each `clk` rising edge with `run`=1, `state` moves to its successor. With `run`=0 all registers hold. Outputs are registered or pure decodes of `state`; no combinational path from `instr` to `state`.
- **Fetch.** 0x00 → 0x0F → 0x01. The RAM output is latched into the instruction register during 0x0F. The opcode is sampled from `instr[15:12]` only in 0x01.
- **Dispatch from 0x01**, by opcode:
  - 0 load → 0x02
  - 1 move → 0x03
  - 2 ldpc → 0x04
  - 3 branch → 0x05
  - 4 sub → 0x06
  - 5 add → 0x09
  - 6 xor → 0x0C
  - 7 push → 0x13
  - 8 pop → 0x17
  - 9 call → 0x1B
  - A ret → 0x21
  - B–F (F see feature) → set `illegal`, go to 0x00 (NOP behaviour, PC not advanced).
- **Execute chains.** Each arrow is one cycle. The final state always returns to 0x00.
  - Single-cycle: 0x02, 0x03, 0x04, 0x05.
  - sub: 0x06 → 0x07 → 0x08.
  - add: 0x09 → 0x0A → 0x0B.
  - xor: 0x0C → 0x0D → 0x0E.
  - push: 0x13 → 0x14 → 0x15 → 0x16.
  - pop: 0x17 → 0x18 → 0x19 → 0x1A.
  - call: 0x1B → 0x1C → 0x1D → 0x1E → 0x1F → 0x20 → 0x25.
  - ret: 0x21 → 0x22 → 0x23 → 0x24.
- **`instr_done`** is high exactly in the final execute state of each chain (0x02, 0x03, 0x04, 0x05, 0x08, 0x0B, 0x0E, 0x16, 0x1A, 0x25, 0x24). It stays high across stall cycles in that state.
- **Instruction latency** (fetch + execute cycles, `run` held high): load/move/ldpc/branch 4; sub/add/xor 6; push/pop 7; call 10; ret 7.
- **Unreachable codes.** Any code not listed above (including 0x10–0x12, 0x26–0xFE) → next state 0x00 and sets `illegal`. Codes 0x10–0x12 and 0x26–0xFE are never produced in normal operation.
- **Sticky flag.** `illegal` clears only on reset.
- **Opcode stability.** Changes of `instr` outside state 0x01 have no effect.

Optional Feature:
- Macro `CONTROL_SEQUENCER_HALT_EN`.
- **Defined:** opcode F in 0x01 → state 0xFF, `halted`=1, no `illegal`. 0xFF holds regardless of `run` until reset. The decoder default branch makes 0xFF drive all strobes low.
- **Undefined:** opcode F is illegal like B–E, and `halted` is tied to 0.

Test Plan:
- **Reset and fetch:** deassert `resetn` mid-add (`state`=0x0A) → `state`=0x00 asynchronously, `illegal`=0. Release with `run`=1 → observe 0x00, 0x0F, 0x01 on successive edges.
- **Add latency:** `instr`=0x5120, `run`=1 → sequence 0x00, 0x0F, 0x01, 0x09, 0x0A, 0x0B, 0x00. `instr_done` high only in 0x0B.
- **Call chain with stall:** `instr`=0x9000, drop `run` for 3 cycles while in 0x1D → `state` holds 0x1D for 3 cycles. It then continues 0x1E, 0x1F, 0x20, 0x25, 0x00. `instr_done` pulses at 0x25.
- **Illegal opcode:** `instr`=0xC000 → 0x01 then 0x00. `illegal`=1 and stays 1 through a following legal move (0x1340 → 0x03).
- **Opcode sampling:** change `instr` from 0x7000 to 0x0000 while in 0x14 → push chain completes (0x15, 0x16, 0x00) unaffected.
- **Halt:** with `CONTROL_SEQUENCER_HALT_EN` and `instr`=0xF000 → `state`=0xFF, `halted`=1 for 20+ cycles with `run`=1, until `resetn` low. Without the macro → 0x00 and `illegal`=1.
